le_store_writer: RTL and testbench

- Write-side counterpart of the little-endian byte-array fetch memory.
- Accepts one RISC-V store per handshake: SB, SH, SW or SD, with a 64-bit address and 64-bit data.
- Commits the store into a 2**ADDR_W-byte array, one byte per clock, least significant byte at the lowest address.
- Provides a combinational 32-bit little-endian read-back port so the bench and core can observe committed bytes.

---
 rtl/le_store_writer_pkg.sv | 29 ++
 rtl/le_byte_mem.sv | 30 +++
 rtl/le_store_writer.sv | 107 ++++++++++
 tb/tb_le_store_writer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/le_store_writer_pkg.sv
// Shared types and helpers for the little-endian store writer.
package le_store_writer_pkg;

   // RISC-V store size encodings (funct3[1:0] of SB/SH/SW/SD).
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StDone
   } wr_state_e;

   // Number of bytes a store of the given size commits.
   function automatic logic [3:0] size_to_bytes(input logic [1:0] size);
      logic [3:0] n;
      unique case (size)
         SZ_B:    n = 4'd1;
         SZ_H:    n = 4'd2;
         SZ_W:    n = 4'd4;
         SZ_D:    n = 4'd8;
         default: n = 4'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/le_byte_mem.sv
// Byte-wide array with one synchronous write port and a combinational
// 32-bit little-endian read port whose lanes wrap around the array end.
module le_byte_mem #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [7:0]        wbyte_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [31:0]       rdata_o
);

   logic [7:0] mem_q [2**ADDR_W];

   // Commit one byte per clock when enabled; no reset on the array.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wbyte_i;
      end
   end

   // Lane k reads (raddr + k) mod depth; the adder width gives the wrap.
   for (genvar k = 0; k < 4; k++) begin : g_lane
      logic [ADDR_W-1:0] lane_addr;
      assign lane_addr          = raddr_i + ADDR_W'(k);
      assign rdata_o[8*k +: 8]  = mem_q[lane_addr];
   end

endmodule

// File: rtl/le_store_writer.sv
// Accepts one SB/SH/SW/SD store per handshake and commits it into a byte
// array one byte per clock, least significant byte at the lowest address.
module le_store_writer
   import le_store_writer_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned XLEN   = 64
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [XLEN-1:0] req_addr_i,
   input  logic [XLEN-1:0] req_data_i,
   input  logic [1:0]      req_size_i,
   output logic            busy_o,
   output logic            done_o,
   input  logic [XLEN-1:0] rd_addr_i,
   output logic [31:0]     rd_data_o
);

   wr_state_e         state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [ADDR_W-1:0] base_q;
   logic [XLEN-1:0]   data_q;
   logic [3:0]        nbytes_q;
   logic              accept;
   logic              write_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [7:0]        mem_wbyte;
   logic              unused_addr_bits;

   // Address bits above the decoded range are deliberately ignored.
   assign unused_addr_bits = ^{req_addr_i[XLEN-1:ADDR_W], rd_addr_i[XLEN-1:ADDR_W]};

   // State and byte index; reset abandons any store in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Request latch, loaded only on an accepted handshake.
   always_ff @(posedge clk_i) begin
      if (accept && !rst_i) begin
         base_q   <= req_addr_i[ADDR_W-1:0];
         data_q   <= req_data_i;
         nbytes_q <= size_to_bytes(req_size_i);
      end
   end

   // Next state, handshake outputs and byte-write enable.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      accept      = 1'b0;
      write_en    = 1'b0;
      req_ready_o = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      unique case (state_q)
         StIdle: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               accept  = 1'b1;
               idx_d   = '0;
               state_d = StWrite;
            end
         end
         StWrite: begin
            busy_o   = 1'b1;
            write_en = 1'b1;
            idx_d    = idx_q + 4'd1;
            if (idx_q == nbytes_q - 4'd1) begin
               state_d = StDone;
            end
         end
         StDone: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // A reset edge must not commit the byte that would otherwise land on it.
   assign mem_we    = write_en && !rst_i;
   assign mem_waddr = base_q + ADDR_W'(idx_q);
   assign mem_wbyte = data_q[8*idx_q[2:0] +: 8];

   le_byte_mem #(
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (mem_we),
      .waddr_i (mem_waddr),
      .wbyte_i (mem_wbyte),
      .raddr_i (rd_addr_i[ADDR_W-1:0]),
      .rdata_o (rd_data_o)
   );

endmodule

// File: tb/tb_le_store_writer.sv
// Bench for le_store_writer: timestamp-based reference model, per-cycle
// compare process, directed literal checks and a randomized phase.
module tb_le_store_writer;
   import le_store_writer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic [63:0] req_data;
   logic [1:0]  req_size;
   logic        busy;
   logic        done;
   logic [63:0] rd_addr;
   logic [31:0] rd_data;

   le_store_writer #(
      .ADDR_W (10),
      .XLEN   (64)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_addr_i  (req_addr),
      .req_data_i  (req_data),
      .req_size_i  (req_size),
      .busy_o      (busy),
      .done_o      (done),
      .rd_addr_i   (rd_addr),
      .rd_data_o   (rd_data)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: a store accepted at edge A with N bytes commits byte k
   // at edge A+k+1, is busy for cycles A..A+N-1, signals done in cycle A+N
   // and is ready again from cycle A+N+1.
   int          cyc      = 0;
   bit          m_active = 1'b0;
   int          m_acc;
   int          m_base;
   int          m_n;
   logic [63:0] m_data;
   logic [7:0]  m_mem [1024];
   bit          rd_en    = 1'b0;
   int          busy_cnt = 0;
   int          done_cnt = 0;

   initial begin
      int k;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            m_active = 1'b0;
         end else if (m_active) begin
            k = cyc - m_acc - 1;
            if (k >= 0 && k < m_n) m_mem[(m_base + k) % 1024] = m_data[8*k +: 8];
            if (cyc == m_acc + m_n + 1) m_active = 1'b0;
         end else if (req_valid) begin
            m_active = 1'b1;
            m_acc    = cyc;
            m_base   = int'(req_addr[9:0]);
            m_data   = req_data;
            m_n      = 1 << req_size;
         end
      end
   end

   // Compare DUT outputs against the model every cycle, away from the edge.
   initial begin
      int          d;
      int          a;
      logic [31:0] exp_rd;
      forever begin
         @(negedge clk);
         if (cyc >= 1) begin
            d = cyc - m_acc;
            chk("ready", 64'(req_ready), 64'(!m_active));
            chk("busy", 64'(busy), 64'(m_active && d < m_n));
            chk("done", 64'(done), 64'(m_active && d == m_n));
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if (rd_en) begin
               a      = int'(rd_addr[9:0]);
               exp_rd = {m_mem[(a + 3) % 1024], m_mem[(a + 2) % 1024],
                         m_mem[(a + 1) % 1024], m_mem[a]};
               chk("rd_data", 64'(rd_data), 64'(exp_rd));
            end
         end
      end
   end

   // Present a request and wait (bounded) for the edge that accepts it.
   task automatic send_req(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
      int t = 0;
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
      req_size  = sz;
      do begin
         @(posedge clk);
         #1;
         t++;
      end while (!(m_active && m_acc == cyc) && t < 40);
      chk("accept_bound", 64'(t < 40), 64'd1);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (m_active && t < 40) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("idle_bound", 64'(t < 40), 64'd1);
   endtask

   // Full store; request inputs are scrambled after acceptance to show
   // that only the latched copy is used.
   task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz);
      send_req(a, d, sz);
      req_valid = 1'b0;
      req_addr  = {$urandom, $urandom};
      req_data  = {$urandom, $urandom};
      req_size  = 2'($urandom);
      wait_idle();
   endtask

   task automatic rd_at(input logic [63:0] a, output logic [31:0] v);
      rd_addr = a;
      #1;
      v = rd_data;
   endtask

   initial begin
      logic [31:0] v;
      int          t;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_addr  = '0;
      req_data  = '0;
      req_size  = '0;
      rd_addr   = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_ready", 64'(req_ready), 64'd1);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);

      // Give every byte a known value before read-back checking starts.
      for (int a = 0; a < 1024; a += 8) do_store(64'(a), {$urandom, $urandom}, SZ_D);
      rd_en = 1'b1;

      // SW with exact occupancy.
      busy_cnt = 0;
      done_cnt = 0;
      do_store(64'h10, 64'h0000_0000_DEAD_BEEF, SZ_W);
      chk("t1_busy_cycles", 64'(busy_cnt), 64'd4);
      chk("t1_done_pulses", 64'(done_cnt), 64'd1);
      rd_at(64'h10, v);
      chk("t1_word", 64'(v), 64'hDEAD_BEEF);
      chk("t1_byte10", 64'(v[7:0]), 64'hEF);
      rd_at(64'h13, v);
      chk("t1_byte13", 64'(v[7:0]), 64'hDE);

      // SD.
      busy_cnt = 0;
      done_cnt = 0;
      do_store(64'h20, 64'h1122_3344_5566_7788, SZ_D);
      chk("t2_busy_cycles", 64'(busy_cnt), 64'd8);
      chk("t2_done_pulses", 64'(done_cnt), 64'd1);
      rd_at(64'h20, v);
      chk("t2_lo", 64'(v), 64'h5566_7788);
      rd_at(64'h24, v);
      chk("t2_hi", 64'(v), 64'h1122_3344);

      // SB then SH over a zeroed word.
      do_store(64'h30, 64'h0, SZ_W);
      do_store(64'h31, 64'hAA, SZ_B);
      rd_at(64'h30, v);
      chk("t3_sb", 64'(v), 64'h0000_AA00);
      do_store(64'h32, 64'hBBCC, SZ_H);
      rd_at(64'h30, v);
      chk("t3_sh", 64'(v), 64'hBBCC_AA00);

      // Wrap at the top of the array, and ignored upper address bits.
      do_store(64'h3FE, 64'h0102_0304, SZ_W);
      rd_at(64'h3FE, v);
      chk("t4_wrap_word", 64'(v), 64'h0102_0304);
      rd_at(64'h0, v);
      chk("t4_wrap_low", 64'(v[15:0]), 64'h0102);
      do_store(64'hFFFF_0000_0000_0010, 64'hA1B2_C3D4, SZ_W);
      rd_at(64'h10, v);
      chk("t4_upper_bits", 64'(v), 64'hA1B2_C3D4);
      rd_at(64'h1234_0000_0000_0010, v);
      chk("t4_rd_upper_bits", 64'(v), 64'hA1B2_C3D4);

      // Reset on the third WRITE edge of an SD.
      do_store(64'h40, 64'h0, SZ_D);
      busy_cnt = 0;
      done_cnt = 0;
      send_req(64'h40, 64'h1122_3344_5566_7788, SZ_D);
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t5_ready_after_reset", 64'(req_ready), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("t5_no_done", 64'(done_cnt), 64'd0);
      chk("t5_busy_cycles", 64'(busy_cnt), 64'd3);
      rd_at(64'h40, v);
      chk("t5_lo", 64'(v), 64'h0000_7788);
      rd_at(64'h44, v);
      chk("t5_hi", 64'(v), 64'h0);

      // Valid held high with changing request fields during a store.
      send_req(64'h50, 64'h1234_5678, SZ_W);
      t = 0;
      while (m_active && t < 40) begin
         req_addr = 64'h100 | 64'($urandom_range(0, 255));
         req_data = {$urandom, $urandom};
         req_size = 2'($urandom);
         @(posedge clk);
         #1;
         t++;
      end
      send_req(64'h58, 64'h9ABC_DEF0, SZ_W);
      req_valid = 1'b0;
      wait_idle();
      rd_at(64'h50, v);
      chk("t6_first", 64'(v), 64'h1234_5678);
      rd_at(64'h58, v);
      chk("t6_second", 64'(v), 64'h9ABC_DEF0);

      // Randomized traffic including resets mid-store and with valid.
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 79) == 0);
         req_valid = ($urandom_range(0, 3) != 0);
         req_addr  = {$urandom, $urandom};
         req_data  = {$urandom, $urandom};
         req_size  = 2'($urandom);
         rd_addr   = {$urandom, $urandom};
         @(posedge clk);
         #1;
      end
      rst       = 1'b0;
      req_valid = 1'b0;
      wait_idle();
      @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
